// File: rtl/alu_pkg.sv
// Shared ALU datapath types: default word width, word type and adder flag bundle.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  typedef logic [ALU_WIDTH-1:0] alu_word_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;
endpackage

// File: rtl/alu_adder_full_adder_cell.sv
// One-bit combinational full adder; the ripple chain in alu_adder is built from these.
module full_adder_cell (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);
  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);
endmodule

// File: rtl/alu_adder.sv
// Registered ripple-carry add/subtract with carry and zero flags, 1-cycle latency, no backpressure.
// Define ALU_ADDER_OVERFLOW_EN to add a registered signed-overflow output.
module alu_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
`ifdef ALU_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH:0]   cy;

  assign bb    = sub ? ~b : b;
  assign cy[0] = c;

  // cy[i] is the carry into bit i; cy[WIDTH] is the carry out of the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_cell (
      .s  (sum_d[i]),
      .co (cy[i+1]),
      .x  (a[i]),
      .y  (bb[i]),
      .ci (cy[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
`ifdef ALU_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else if (in_valid) begin
      sum   <= sum_d;
      carry <= cy[WIDTH];
      zero  <= (sum_d == '0);
`ifdef ALU_ADDER_OVERFLOW_EN
      overflow <= cy[WIDTH] ^ cy[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end
endmodule

// File: tb/tb_alu_adder.sv
// Bench for alu_adder at WIDTH=1 and WIDTH=8; checks overflow too when ALU_ADDER_OVERFLOW_EN is defined.
module tb_alu_adder;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, sub, c;
  logic [0:0] a1, b1, sum1;
  logic       carry1, zero1, out_valid1;
  logic [7:0] a8, b8, sum8;
  logic       carry8, zero8, out_valid8;
`ifdef ALU_ADDER_OVERFLOW_EN
  logic       overflow1, overflow8;
`endif

  alu_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a1), .b(b1), .c(c),
    .sum(sum1), .carry(carry1), .zero(zero1), .out_valid(out_valid1)
`ifdef ALU_ADDER_OVERFLOW_EN
    , .overflow(overflow1)
`endif
  );

  alu_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a8), .b(b8), .c(c),
    .sum(sum8), .carry(carry8), .zero(zero8), .out_valid(out_valid8)
`ifdef ALU_ADDER_OVERFLOW_EN
    , .overflow(overflow8)
`endif
  );

  typedef struct {
    logic [63:0] sum;
    alu_flags_t  f;
    logic        valid;
  } exp_t;

  typedef struct {
    bit a, b, c, s, co;
  } vec1_t;

  exp_t e1, e8;
  int   checks = 0;
  int   errors = 0;

  // Reference: plain integer add of a, possibly-inverted b and carry-in; signed
  // overflow from operand/result signs.
  function automatic exp_t model(input exp_t prev, input int w, input bit r, input bit v,
                                 input bit s, input bit ci, input longint unsigned av,
                                 input longint unsigned bv);
    exp_t n;
    longint unsigned mask, bbv, total;
    n = prev;
    mask = (longint'(1) << w) - 1;
    bbv = s ? (~bv & mask) : (bv & mask);
    total = (av & mask) + bbv + longint'(ci);
    if (r) begin
      n.sum = '0; n.f.carry = 1'b0; n.f.zero = 1'b1; n.f.overflow = 1'b0; n.valid = 1'b0;
    end else begin
      n.valid = v;
      if (v) begin
        n.sum        = total & mask;
        n.f.carry    = ((total >> w) & 1) != 0;
        n.f.zero     = (total & mask) == 0;
        n.f.overflow = (((av >> (w-1)) & 1) == ((bbv >> (w-1)) & 1)) &&
                       (((total >> (w-1)) & 1) != ((av >> (w-1)) & 1));
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    e1 = model(e1, 1, rst, in_valid, sub, c, 64'(a1), 64'(b1));
    e8 = model(e8, 8, rst, in_valid, sub, c, 64'(a8), 64'(b8));
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " w1 sum"},   64'(sum1),       e1.sum);
    chk({tag, " w1 carry"}, 64'(carry1),     64'(e1.f.carry));
    chk({tag, " w1 zero"},  64'(zero1),      64'(e1.f.zero));
    chk({tag, " w1 valid"}, 64'(out_valid1), 64'(e1.valid));
    chk({tag, " w8 sum"},   64'(sum8),       e8.sum);
    chk({tag, " w8 carry"}, 64'(carry8),     64'(e8.f.carry));
    chk({tag, " w8 zero"},  64'(zero8),      64'(e8.f.zero));
    chk({tag, " w8 valid"}, 64'(out_valid8), 64'(e8.valid));
`ifdef ALU_ADDER_OVERFLOW_EN
    chk({tag, " w1 ovf"},   64'(overflow1),  64'(e1.f.overflow));
    chk({tag, " w8 ovf"},   64'(overflow8),  64'(e8.f.overflow));
`endif
  endtask

  task automatic drive8(input bit v, input bit s, input bit ci, input logic [7:0] av,
                        input logic [7:0] bv);
    in_valid = v; sub = s; c = ci; a8 = av; b8 = bv; a1 = 1'b0; b1 = 1'b0;
  endtask

  initial begin
    vec1_t tbl[8];
    tbl[0] = '{0,0,0, 0,0}; tbl[1] = '{1,0,0, 1,0};
    tbl[2] = '{0,1,0, 1,0}; tbl[3] = '{1,1,0, 0,1};
    tbl[4] = '{0,0,1, 1,0}; tbl[5] = '{1,0,1, 0,1};
    tbl[6] = '{0,1,1, 0,1}; tbl[7] = '{1,1,1, 1,1};

    e1 = '{sum: '0, f: '{1'b0, 1'b1, 1'b0}, valid: 1'b0};
    e8 = e1;
    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; c = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    #1;
    step(); step();
    chk("reset w8 sum", 64'(sum8), 64'h0);
    chk("reset w8 zero", 64'(zero8), 64'h1);
    chk("reset w8 valid", 64'(out_valid8), 64'h0);
    chk("reset w1 carry", 64'(carry1), 64'h0);
    rst = 1'b0;

    // WIDTH=1 full-adder truth table, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; sub = 1'b0;
      a1 = tbl[i].a; b1 = tbl[i].b; c = tbl[i].c;
      a8 = 8'($urandom); b8 = 8'($urandom);
      chk($sformatf("w1 vec%0d before edge", i), 64'(sum1), 64'(i == 0 ? 1'b0 : tbl[i-1].s));
      step();
      chk($sformatf("w1 vec%0d sum", i), 64'(sum1), 64'(tbl[i].s));
      chk($sformatf("w1 vec%0d carry", i), 64'(carry1), 64'(tbl[i].co));
      chk($sformatf("w1 vec%0d valid", i), 64'(out_valid1), 64'h1);
      check_model($sformatf("w1 vec%0d", i));
    end

    drive8(1, 0, 0, 8'hFF, 8'h01); step();
    chk("add wrap sum", 64'(sum8), 64'h00);
    chk("add wrap carry", 64'(carry8), 64'h1);
    chk("add wrap zero", 64'(zero8), 64'h1);
    drive8(1, 0, 1, 8'h12, 8'h34); step();
    chk("add cin sum", 64'(sum8), 64'h47);
    chk("add cin carry", 64'(carry8), 64'h0);
    chk("add cin zero", 64'(zero8), 64'h0);

    for (int k = 0; k < 3; k++) begin
      drive8(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      a1 = 1'($urandom); b1 = 1'($urandom);
      step();
      chk($sformatf("hold%0d sum", k), 64'(sum8), 64'h47);
      chk($sformatf("hold%0d carry", k), 64'(carry8), 64'h0);
      chk($sformatf("hold%0d zero", k), 64'(zero8), 64'h0);
      chk($sformatf("hold%0d valid", k), 64'(out_valid8), 64'h0);
      check_model($sformatf("hold%0d", k));
    end

    drive8(1, 1, 1, 8'h05, 8'h07); step();
    chk("sub neg sum", 64'(sum8), 64'hFE);
    chk("sub neg carry", 64'(carry8), 64'h0);
    drive8(1, 1, 1, 8'h07, 8'h05); step();
    chk("sub pos sum", 64'(sum8), 64'h02);
    chk("sub pos carry", 64'(carry8), 64'h1);
    drive8(1, 1, 0, 8'h07, 8'h05); step();
    chk("sub nocin sum", 64'(sum8), 64'h01);

`ifdef ALU_ADDER_OVERFLOW_EN
    drive8(1, 0, 0, 8'h7F, 8'h01); step();
    chk("ovf pos", 64'(overflow8), 64'h1);
    drive8(1, 0, 0, 8'h80, 8'hFF); step();
    chk("ovf neg", 64'(overflow8), 64'h1);
    chk("ovf neg carry", 64'(carry8), 64'h1);
    drive8(1, 0, 0, 8'h01, 8'h01); step();
    chk("ovf none", 64'(overflow8), 64'h0);
`endif

    // reset wins over a simultaneous valid operand set
    rst = 1'b1; drive8(1, 0, 0, 8'hFF, 8'hFF); step();
    chk("rst sum", 64'(sum8), 64'h0);
    chk("rst carry", 64'(carry8), 64'h0);
    chk("rst zero", 64'(zero8), 64'h1);
    chk("rst valid", 64'(out_valid8), 64'h0);
    rst = 1'b0; drive8(0, 0, 0, 8'h03, 8'h04); step();
    chk("post rst idle valid", 64'(out_valid8), 64'h0);
    drive8(1, 0, 0, 8'h03, 8'h04); step();
    chk("post rst first valid", 64'(out_valid8), 64'h1);
    chk("post rst first sum", 64'(sum8), 64'h07);

    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 29) == 0);
      in_valid = 1'($urandom); sub = 1'($urandom); c = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      step();
      check_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
